// File: rtl/ysyx_23060203_axi_pkg.sv
// Shared AXI4 encodings and responder state type for the instruction-memory
// read responder and its companion burst-address helper.
package ysyx_23060203_axi_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;

    typedef enum logic [1:0] {
        RSP_IDLE,
        RSP_WAIT,
        RSP_BURST
    } rsp_state_t;

endpackage

// File: rtl/ysyx_23060203_axi_burst_addr.sv
// Combinational next-beat byte address for an AXI4 burst of 32-bit beats.
// Shared between the read responder and the write responder.
module ysyx_23060203_axi_burst_addr
    import ysyx_23060203_axi_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [7:0]  len,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);

    logic [31:0] wrap_mask;

    always_comb begin
        // Wrap window is (len+1) words; only meaningful for power-of-two sizes.
        wrap_mask = (({24'd0, len} + 32'd1) << 2) - 32'd1;
        case (burst)
            AXI_BURST_FIXED: next_addr = addr;
            AXI_BURST_WRAP:  next_addr = (addr & ~wrap_mask) | ((addr + 32'd4) & wrap_mask);
            default:         next_addr = addr + 32'd4;
        endcase
    end

endmodule

// File: rtl/ysyx_23060203_imem_axi_rsp.sv
// AXI4 read-only responder backed by a local word array: one AR at a time,
// a fixed wait, then arlen+1 registered R beats with back-pressure.
module ysyx_23060203_imem_axi_rsp
    import ysyx_23060203_axi_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic [3:0]  rid
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0] mem [0:DEPTH_WORDS-1];

    rsp_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  id_q, id_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  beat_q, beat_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;

    logic [31:0] next_addr;
    logic        load;
    logic [31:0] ld_addr;
    logic [7:0]  ld_len;
    logic [2:0]  ld_size;
    logic [1:0]  ld_burst;
    logic [7:0]  ld_beat;
    logic [1:0]  ld_resp;
    logic [31:0] ld_off;

    ysyx_23060203_axi_burst_addr u_burst_addr (
        .addr      (addr_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    function automatic logic [1:0] beat_resp(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
        logic        slverr;
        logic        in_range;
        logic [31:0] off;
        off      = addr - ADDR_BASE;
        in_range = (off >> (IDX_W + 2)) == 32'd0;
        slverr   = (size != AXI_SIZE_WORD) || (burst == 2'b11) || (addr[1:0] != 2'b00) ||
                   ((burst == AXI_BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
        if (slverr)
            return AXI_RESP_SLVERR;
        if (!in_range)
            return AXI_RESP_DECERR;
        return AXI_RESP_OKAY;
    endfunction

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        id_d     = id_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        load     = 1'b0;
        ld_addr  = addr_q;
        ld_len   = len_q;
        ld_size  = size_q;
        ld_burst = burst_q;
        ld_beat  = 8'd0;

        case (state_q)
            RSP_IDLE: begin
                if (arvalid) begin
                    addr_d  = araddr;
                    id_d    = arid;
                    len_d   = arlen;
                    size_d  = arsize;
                    burst_d = arburst;
                    cnt_d   = 4'(LATENCY);
                    beat_d  = 8'd0;
                    if (LATENCY == 0) begin
                        // Zero latency: the first beat comes straight from the AR bus.
                        load     = 1'b1;
                        ld_addr  = araddr;
                        ld_len   = arlen;
                        ld_size  = arsize;
                        ld_burst = arburst;
                        state_d  = RSP_BURST;
                    end else begin
                        state_d  = RSP_WAIT;
                    end
                end
            end
            RSP_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    load    = 1'b1;
                    state_d = RSP_BURST;
                end
            end
            RSP_BURST: begin
                if (rready) begin
                    if (rlast_q) begin
                        rlast_d = 1'b0;
                        state_d = RSP_IDLE;
                    end else begin
                        load    = 1'b1;
                        ld_addr = next_addr;
                        ld_beat = beat_q + 8'd1;
                        addr_d  = next_addr;
                        beat_d  = beat_q + 8'd1;
                    end
                end
            end
            default: state_d = RSP_IDLE;
        endcase

        ld_resp = beat_resp(ld_addr, ld_len, ld_size, ld_burst);
        ld_off  = ld_addr - ADDR_BASE;
        if (load) begin
            rresp_d = ld_resp;
            rdata_d = (ld_resp == AXI_RESP_OKAY) ? mem[ld_off[IDX_W+1:2]] : 32'd0;
            rlast_d = (ld_beat == ld_len);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RSP_IDLE;
            addr_q  <= 32'd0;
            id_q    <= 4'd0;
            len_q   <= 8'd0;
            size_q  <= 3'd0;
            burst_q <= 2'd0;
            cnt_q   <= 4'd0;
            beat_q  <= 8'd0;
            rdata_q <= 32'd0;
            rresp_q <= 2'd0;
            rlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            rlast_q <= rlast_d;
        end
    end

    assign arready = (state_q == RSP_IDLE);
    assign rvalid  = (state_q == RSP_BURST);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rid     = id_q;

endmodule

// File: tb/tb_ysyx_23060203_imem_axi_rsp.sv
// Bench for the instruction-memory AXI read responder: directed bursts plus
// random bursts checked against an address/response model of the AXI rules.
module tb_ysyx_23060203_imem_axi_rsp;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam int          LAT   = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] araddr = 32'd0;
    logic [3:0]  arid = 4'd0;
    logic [7:0]  arlen = 8'd0;
    logic [2:0]  arsize = 3'b010;
    logic [1:0]  arburst = 2'b01;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    logic [31:0] model [0:DEPTH-1];
    int tests = 0;
    int fails = 0;

    ysyx_23060203_imem_axi_rsp #(
        .ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT), .INIT_FILE("")
    ) dut (
        .clock(clock), .reset(reset),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected byte address of beat i, from the AXI burst definitions.
    function automatic logic [31:0] beat_addr(input logic [31:0] a0, input logic [7:0] len,
                                              input logic [1:0] burst, input int i);
        logic [31:0] bytes, lo;
        bytes = (32'(len) + 32'd1) * 32'd4;
        case (burst)
            2'b00: return a0;
            2'b10: begin
                lo = a0 - (a0 % bytes);
                return lo + ((a0 - lo + 32'(4 * i)) % bytes);
            end
            default: return a0 + 32'(4 * i);
        endcase
    endfunction

    task automatic exp_beat(input logic [31:0] a0, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int i,
                            output logic [31:0] d, output logic [1:0] r);
        logic [31:0] a;
        bit wrap_ok, slv, dec;
        a = beat_addr(a0, len, burst, i);
        wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        slv = (size != 3'b010) || (burst == 2'b11) || (a[1:0] != 2'b00) ||
              (burst == 2'b10 && !wrap_ok);
        dec = (64'(a) < 64'(BASE)) || (64'(a) >= 64'(BASE) + 64'(4 * DEPTH));
        if (slv) begin r = 2'b10; d = 32'd0; end
        else if (dec) begin r = 2'b11; d = 32'd0; end
        else begin r = 2'b00; d = model[(a - BASE) >> 2]; end
    endtask

    // mode 0: rready always 1; 1: toggling 1,0,1,...; 2: random.
    task automatic run_burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int mode,
                             input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        int i, budget;
        bit tog;
        @(negedge clock);
        chk({tag, "_arready"}, 32'(arready), 32'd1);
        arvalid = 1'b1; araddr = a; arid = id; arlen = len; arsize = size; arburst = burst;
        rready = 1'b0;
        @(posedge clock);
        for (int k = 0; k < LAT; k++) begin
            @(negedge clock);
            arvalid = 1'b0;
            araddr = ~a;
            chk({tag, "_wait_rvalid"}, 32'(rvalid), 32'd0);
            @(posedge clock);
        end
        @(negedge clock);
        arvalid = 1'b0;
        i = 0; budget = 400; tog = 1'b1;
        while (i <= int'(len) && budget > 0) begin
            exp_beat(a, len, size, burst, i, d, r);
            chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
            chk({tag, "_rdata"}, rdata, d);
            chk({tag, "_rresp"}, 32'(rresp), 32'(r));
            chk({tag, "_rlast"}, 32'(rlast), 32'(i == int'(len)));
            chk({tag, "_rid"}, 32'(rid), 32'(id));
            case (mode)
                0: rready = 1'b1;
                1: begin rready = tog; tog = ~tog; end
                default: rready = 1'($urandom_range(0, 1));
            endcase
            @(posedge clock);
            if (rready) i++;
            budget--;
            @(negedge clock);
        end
        chk({tag, "_timeout"}, 32'(budget > 0), 32'd1);
        rready = 1'b0;
        chk({tag, "_end_rvalid"}, 32'(rvalid), 32'd0);
        chk({tag, "_end_arready"}, 32'(arready), 32'd1);
    endtask

    initial begin
        logic [31:0] a, v;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [2:0]  size;
        int sel;

        for (int w = 0; w < DEPTH; w++) begin
            v = $urandom;
            model[w] = v;
            dut.mem[w] = v;
        end

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_arready", 32'(arready), 32'd1);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rlast", 32'(rlast), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        chk("rst_rid", 32'(rid), 32'd0);
        reset = 1'b0;

        run_burst(32'h8000_0000, 4'h1, 8'd0, 3'b010, 2'b01, 0, "single");
        run_burst(32'h8000_0010, 4'h2, 8'd3, 3'b010, 2'b01, 1, "incr_toggle");
        run_burst(32'h8000_0018, 4'h3, 8'd3, 3'b010, 2'b10, 0, "wrap4");
        run_burst(32'h7FFF_FFFC, 4'h4, 8'd1, 3'b010, 2'b01, 0, "below_base");
        run_burst(32'h8000_0100, 4'hA, 8'd2, 3'b011, 2'b01, 2, "bad_size");
        run_burst(32'h8000_3FF8, 4'h5, 8'd3, 3'b010, 2'b01, 2, "top_edge");
        run_burst(32'h8000_0040, 4'h6, 8'd4, 3'b010, 2'b00, 1, "fixed");
        run_burst(32'h8000_0044, 4'h7, 8'd2, 3'b010, 2'b10, 0, "wrap_badlen");
        run_burst(32'h8000_0042, 4'h8, 8'd1, 3'b010, 2'b01, 0, "misaligned");

        // Reset mid-burst after the first of four beats.
        @(negedge clock);
        arvalid = 1'b1; araddr = 32'h8000_0200; arid = 4'h9; arlen = 8'd3;
        arsize = 3'b010; arburst = 2'b01;
        @(posedge clock);
        @(negedge clock);
        arvalid = 1'b0;
        repeat (LAT) @(negedge clock);
        chk("mid_rvalid_before", 32'(rvalid), 32'd1);
        rready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rready = 1'b0;
        chk("mid_beat1_data", rdata, model[129]);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
        chk("mid_rst_arready", 32'(arready), 32'd1);
        chk("mid_rst_rid", 32'(rid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        run_burst(32'h8000_0300, 4'hB, 8'd1, 3'b010, 2'b01, 0, "after_rst");

        for (int n = 0; n < 24; n++) begin
            sel = int'($urandom_range(0, 9));
            a = BASE + 32'($urandom_range(0, DEPTH - 1) << 2);
            if (sel == 0) a = BASE + 32'(4 * DEPTH) - 32'($urandom_range(0, 3) << 2);
            if (sel == 1) a = a | 32'($urandom_range(1, 3));
            len = 8'($urandom_range(0, 15));
            burst = 2'($urandom_range(0, 3));
            if (burst == 2'b10 && sel < 8) len = 8'((1 << $urandom_range(1, 4)) - 1);
            size = (sel == 9) ? 3'($urandom_range(0, 7)) : 3'b010;
            run_burst(a, 4'($urandom_range(0, 15)), len, size, burst,
                      int'($urandom_range(0, 2)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
